// File: rtl/redcim_pkg.sv
// rtl/redcim_pkg.sv - shared types and constants for the ReDCIM job scheduler
package redcim_pkg;

    localparam int BF16_W = 16;

    typedef logic [BF16_W-1:0] bf16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; pointer register is owned by the caller
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid
);

    // Index of the k-th requester counted from the pointer, wrapping modulo NREQ.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % 32'(NREQ);
        return IW'(s);
    endfunction

    logic [IW-1:0] cand;

    // Scan from the pointer and take the first asserted request.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = wrap_idx(rr_ptr, 32'(k));
                if (!gnt_valid && req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
            if (gnt_valid) begin
                gnt = NREQ'(1) << gnt_idx;
            end
        end
    end

endmodule

// File: rtl/redcim_scheduler.sv
// rtl/redcim_scheduler.sv - shares one ReDCIM dot-product engine among NREQ requesters
module redcim_scheduler
    import redcim_pkg::*;
#(
    parameter  int SIZE    = 2,
    parameter  int NREQ    = 2,
    parameter  int LATENCY = 8,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int VW      = BF16_W * SIZE,
    localparam int CW      = $clog2(LATENCY + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*VW-1:0]   req_a,
    input  logic [NREQ*VW-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BF16_W-1:0]    rsp_data,
    output logic [IW-1:0]        rsp_id,
    output logic                 cim_start,
    output logic [VW-1:0]        cim_a,
    output logic [VW-1:0]        cim_b,
    input  logic [BF16_W-1:0]    cim_out,
    output logic                 busy
);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] op_a_q, op_a_d;
    logic [VW-1:0] op_b_q, op_b_d;
    bf16_t         rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_valid;
    logic            arb_en;
    logic [VW-1:0]   sel_a, sel_b;

    // Grants are only offered while idle and out of reset, so req_ready is zero elsewhere.
    assign arb_en = rst_n && (state_q == IDLE);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .en        (arb_en),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Select the granted requester's operand slices.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*VW +: VW];
                sel_b = req_b[i*VW +: VW];
            end
        end
    end

    // Job sequencing: accept, pulse start, wait the fixed engine latency, hold the result.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = cim_out;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;
    assign cim_start = (state_q == ISSUE);
    assign cim_a     = op_a_q;
    assign cim_b     = op_b_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_redcim_scheduler.sv
// tb/tb_redcim_scheduler.sv - scoreboard bench for redcim_scheduler (three configurations)
module tb_redcim_scheduler;

    localparam int L  = 8;
    localparam int L4 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- main instance: NREQ=2, LATENCY=8 ----------------
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [0:0]  rsp_id;
    logic        cim_start;
    logic [31:0] cim_a, cim_b;
    logic [15:0] cim_out;
    logic        busy;

    redcim_scheduler #(.SIZE(2), .NREQ(2), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .cim_start(cim_start), .cim_a(cim_a),
        .cim_b(cim_b), .cim_out(cim_out), .busy(busy)
    );

    int          e_cnt = 0;
    logic [15:0] e_val = '0;
    always @(posedge clk) begin
        if (cim_start) begin
            e_cnt <= L;
            e_val <= cim_a[15:0] + cim_b[15:0];
        end else if (e_cnt > 0) begin
            e_cnt <= e_cnt - 1;
        end
    end
    assign cim_out = (e_cnt == 1) ? e_val : 16'hxxxx;

    logic [31:0] fa0[$], fb0[$], fa1[$], fb1[$];

    always begin : feeder
        logic [1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (hs[0] && fa0.size() > 0) begin void'(fa0.pop_front()); void'(fb0.pop_front()); end
        if (hs[1] && fa1.size() > 0) begin void'(fa1.pop_front()); void'(fb1.pop_front()); end
        req_valid[0] = (fa0.size() > 0);
        req_valid[1] = (fa1.size() > 0);
        req_a[31:0]  = (fa0.size() > 0) ? fa0[0] : 32'h0;
        req_b[31:0]  = (fb0.size() > 0) ? fb0[0] : 32'h0;
        req_a[63:32] = (fa1.size() > 0) ? fa1[0] : 32'h0;
        req_b[63:32] = (fb1.size() > 0) ? fb1[0] : 32'h0;
    end

    typedef struct { int id; logic [15:0] data; } exp_t;
    exp_t exp_q[$];
    int   exp_gnt_q[$];
    int   acc_q[$];
    int   last_acc = -1;
    int   last_hs = -100;
    bit   chk_space = 1'b0;
    bit   chk_next = 1'b0;
    bit   prev_valid = 1'b0;
    int   n_rsp = 0;
    int   n_start = 0;
    int   n_acc = 0;

    always begin : mon_main
        int   g;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            acc_q.delete();
            last_acc   = -1;
            prev_valid = 1'b0;
        end else begin
            if ((req_valid & req_ready) != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                if (exp_gnt_q.size() == 0) chk("unexpected_grant", 32'(g), 32'hFFFF_FFFF);
                else chk("grant_idx", 32'(g), 32'(exp_gnt_q.pop_front()));
                if (chk_space && last_acc >= 0) chk("accept_spacing", cyc - last_acc, L + 3);
                if (chk_next) begin
                    chk("accept_after_hs", cyc - last_hs, 1);
                    chk_next = 1'b0;
                end
                last_acc = cyc;
                acc_q.push_back(cyc);
                n_acc++;
            end
            if (cim_start) begin
                chk("start_after_accept", cyc - last_acc, 1);
                n_start++;
            end
            if (rsp_valid && !prev_valid) begin
                if (acc_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
                else chk("rsp_latency", cyc - acc_q.pop_front(), L + 2);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
                last_hs = cyc;
                n_rsp++;
            end
            prev_valid = rsp_valid;
        end
    end

    // ---------------- fairness instance: NREQ=4, LATENCY=2 ----------------
    logic [3:0]   r4_valid = '0;
    logic [3:0]   r4_ready;
    logic [127:0] r4_a = '0;
    logic [127:0] r4_b = '0;
    logic         rsp4_valid;
    logic         rsp4_ready = 1'b1;
    logic [15:0]  rsp4_data;
    logic [1:0]   rsp4_id;
    logic         start4;
    logic [31:0]  c4_a, c4_b;
    logic [15:0]  c4_out;
    logic         busy4;

    redcim_scheduler #(.SIZE(2), .NREQ(4), .LATENCY(L4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(r4_valid), .req_ready(r4_ready),
        .req_a(r4_a), .req_b(r4_b), .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready),
        .rsp_data(rsp4_data), .rsp_id(rsp4_id), .cim_start(start4), .cim_a(c4_a),
        .cim_b(c4_b), .cim_out(c4_out), .busy(busy4)
    );

    int          e4_cnt = 0;
    logic [15:0] e4_val = '0;
    always @(posedge clk) begin
        if (start4) begin
            e4_cnt <= L4;
            e4_val <= c4_a[15:0] + c4_b[15:0];
        end else if (e4_cnt > 0) begin
            e4_cnt <= e4_cnt - 1;
        end
    end
    assign c4_out = (e4_cnt == 1) ? e4_val : 16'hxxxx;

    exp_t exp4_q[$];
    int   n_rsp4 = 0;

    always begin : mon4
        exp_t e;
        @(negedge clk);
        if (rst_n && rsp4_valid && rsp4_ready) begin
            if (exp4_q.size() == 0) chk("unexpected_rsp4", 32'(rsp4_data), 32'hFFFF_FFFF);
            else begin
                e = exp4_q.pop_front();
                chk("rsp4_id", 32'(rsp4_id), 32'(e.id));
                chk("rsp4_data", 32'(rsp4_data), 32'(e.data));
            end
            n_rsp4++;
        end
    end

    // ---------------- degenerate instance: NREQ=1, LATENCY=1 ----------------
    logic [0:0]  r1_valid = '0;
    logic [0:0]  r1_ready;
    logic [31:0] r1_a = '0;
    logic [31:0] r1_b = '0;
    logic        rsp1_valid;
    logic        rsp1_ready = 1'b1;
    logic [15:0] rsp1_data;
    logic [0:0]  rsp1_id;
    logic        start1;
    logic [31:0] c1_a, c1_b;
    logic [15:0] c1_out;
    logic        busy1;

    redcim_scheduler #(.SIZE(2), .NREQ(1), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
        .req_a(r1_a), .req_b(r1_b), .rsp_valid(rsp1_valid), .rsp_ready(rsp1_ready),
        .rsp_data(rsp1_data), .rsp_id(rsp1_id), .cim_start(start1), .cim_a(c1_a),
        .cim_b(c1_b), .cim_out(c1_out), .busy(busy1)
    );

    int          e1_cnt = 0;
    logic [15:0] e1_val = '0;
    always @(posedge clk) begin
        if (start1) begin
            e1_cnt <= 1;
            e1_val <= c1_a[15:0] + c1_b[15:0];
        end else if (e1_cnt > 0) begin
            e1_cnt <= e1_cnt - 1;
        end
    end
    assign c1_out = (e1_cnt == 1) ? e1_val : 16'hxxxx;

    exp_t exp1_q[$];
    int   n_rsp1 = 0;
    int   acc1 = -100;
    bit   prev1 = 1'b0;

    always begin : mon1
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (r1_valid[0] && r1_ready[0]) acc1 = cyc;
            if (rsp1_valid && !prev1) chk("l1_rsp_latency", cyc - acc1, 3);
            if (rsp1_valid && rsp1_ready) begin
                if (exp1_q.size() == 0) chk("unexpected_rsp1", 32'(rsp1_data), 32'hFFFF_FFFF);
                else begin
                    e = exp1_q.pop_front();
                    chk("rsp1_id", 32'(rsp1_id), 32'(e.id));
                    chk("rsp1_data", 32'(rsp1_data), 32'(e.data));
                end
                n_rsp1++;
            end
            prev1 = rsp1_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_cim_start"}, 32'(cim_start), 32'd0);
        chk({tag, "_cim_a"},     cim_a,          32'd0);
        chk({tag, "_cim_b"},     cim_b,          32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic wait_count(input string nm, ref int cnt, input int n, input int lim);
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (cnt >= n) break;
        end
        chk(nm, 32'(cnt), 32'(n));
    endtask

    logic [31:0] ca0 [3] = '{32'hFFFF_1000, 32'hFFFF_2000, 32'hFFFF_3000};
    logic [31:0] cb0 [3] = '{32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
    logic [15:0] cd0 [3] = '{16'h1001, 16'h2002, 16'h3003};
    logic [31:0] ca1 [3] = '{32'h5555_0A00, 32'h5555_0B00, 32'h5555_0C00};
    logic [31:0] cb1 [3] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
    logic [15:0] cd1 [3] = '{16'h0A10, 16'h0B20, 16'h0C30};

    initial begin : stim
        int wait_k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single job from requester 0
        @(negedge clk);
        exp_gnt_q.push_back(0);
        exp_q.push_back('{0, 16'h0265});
        fa0.push_back(32'hC2C0_C1BB);
        fb0.push_back(32'h42A3_40AA);
        wait_count("single_rsp_count", n_rsp, 1, 100);

        // backpressure: requester 1 then 0 (pointer is at 1)
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(0);
        exp_q.push_back('{1, 16'h2322});
        exp_q.push_back('{0, 16'h000C});
        fa1.push_back(32'h1111_2222);
        fb1.push_back(32'h3333_0100);
        fa0.push_back(32'h0000_0005);
        fb0.push_back(32'h0000_0007);
        wait_k = 0;
        while (!rsp_valid && wait_k < 50) begin
            @(negedge clk);
            wait_k++;
        end
        chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h2322);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_cim_start", 32'(cim_start), 32'd0);
            chk("bp_cim_a", cim_a, 32'h1111_2222);
        end
        @(posedge clk);
        #1;
        chk_next  = 1'b1;
        rsp_ready = 1'b1;
        wait_count("bp_rsp_count", n_rsp, 3, 100);

        // reset during WAIT of a job from requester 1
        @(negedge clk);
        exp_gnt_q.push_back(1);
        fa1.push_back(32'h0000_AAAA);
        fb1.push_back(32'h0000_1111);
        wait_count("rst_job_started", n_start, 4, 100);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midjob_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // contention: requester 0 must win first after reset
        @(negedge clk);
        chk_space = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fa0.push_back(ca0[k]);
            fb0.push_back(cb0[k]);
            fa1.push_back(ca1[k]);
            fb1.push_back(cb1[k]);
            exp_gnt_q.push_back(0);
            exp_gnt_q.push_back(1);
            exp_q.push_back('{0, cd0[k]});
            exp_q.push_back('{1, cd1[k]});
        end
        wait_count("contention_rsp_count", n_rsp, 9, 200);
        chk_space = 1'b0;
        repeat (15) @(negedge clk);
        chk("total_rsp", 32'(n_rsp), 32'd9);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("grants_drained", 32'(exp_gnt_q.size()), 32'd0);
        chk("starts_eq_accepts", 32'(n_start), 32'(n_acc));

        // fairness on 4 requesters: move pointer to 2, then 1 and 3 contend
        @(posedge clk);
        #1;
        r4_a[63:32] = 32'h0000_0010;
        r4_b[63:32] = 32'h0000_0001;
        r4_valid    = 4'b0010;
        exp4_q.push_back('{1, 16'h0011});
        #1 chk("fair_pre_grant", 32'(r4_ready), 32'b0010);
        @(posedge clk);
        #1 r4_valid = 4'b0000;
        wait_count("fair_pre_rsp", n_rsp4, 1, 50);
        @(posedge clk);
        #1;
        r4_a[63:32]  = 32'h0000_0020;
        r4_b[63:32]  = 32'h0000_0002;
        r4_a[127:96] = 32'h0000_0030;
        r4_b[127:96] = 32'h0000_0003;
        r4_valid     = 4'b1010;
        exp4_q.push_back('{3, 16'h0033});
        exp4_q.push_back('{1, 16'h0022});
        #1 chk("fair_first_grant", 32'(r4_ready), 32'b1000);
        @(posedge clk);
        #1 r4_valid[3] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (r4_ready[1]) break;
        end
        chk("fair_second_grant", 32'(r4_ready), 32'b0010);
        @(posedge clk);
        #1 r4_valid = 4'b0000;
        wait_count("fair_rsp_count", n_rsp4, 3, 50);

        // LATENCY=1, NREQ=1 single job
        @(posedge clk);
        #1;
        r1_a     = 32'hABCD_1234;
        r1_b     = 32'h0000_0101;
        r1_valid = 1'b1;
        exp1_q.push_back('{0, 16'h1335});
        @(posedge clk);
        #1 r1_valid = 1'b0;
        wait_count("l1_rsp_count", n_rsp1, 1, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
